// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - next-PC select, PC/EPC registers and RUN/TRAP sequencing
// Optional macro PC_ALIGN_CHECK_EN: misaligned update targets enter the trap and flag sel_err.
module pc_next_unit #(
  parameter int unsigned          DATA_W       = 32,
  parameter logic [DATA_W-1:0]    RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0]    EXC_VECTOR   = DATA_W'(32'h0000_00FC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        PCsource,
  input  logic [DATA_W-1:0] jump_in,
  input  logic [DATA_W-1:0] epc_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              zero,
  input  logic              exc_req,
  input  logic              err_clr,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] EPC_out,
  output logic [DATA_W-1:0] next_pc,
  output logic              in_trap,
  output logic              sel_err
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [DATA_W-1:0] pc_plus4;
  logic        upd;
  logic        legal;
  logic        misalign;
  logic        run;
  logic        trap_entry;
  logic        pc_load;
  logic        set_err;

  assign pc_plus4 = pc_out + DATA_W'(4);
  assign upd      = pc_write | (pc_write_cond & zero);
  assign legal    = (PCsource <= 3'd4);
  assign run      = (state == RUN);

  // Illegal selects fall back to the current PC so next_pc is always driven.
  always_comb begin
    next_pc = pc_out;
    case (PCsource)
      3'd0:    next_pc = jump_in;
      3'd1:    next_pc = epc_in;
      3'd2:    next_pc = result_in;
      3'd3:    next_pc = ALU_out;
      3'd4:    next_pc = pc_plus4;
      default: next_pc = pc_out;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = |next_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // exc_req outranks any update; a misaligned update is promoted to a trap.
  assign trap_entry = run & (exc_req | (upd & legal & misalign));
  assign pc_load    = run & ~exc_req & upd & legal & ~misalign;
  assign set_err    = run & ~exc_req & upd & (~legal | misalign);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trap_entry) state_nxt = TRAP;
      TRAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    in_trap = (state == TRAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out  <= RESET_VECTOR;
      EPC_out <= '0;
    end else if (trap_entry) begin
      EPC_out <= pc_out;
      pc_out  <= EXC_VECTOR;
    end else if (pc_load) begin
      pc_out  <= next_pc;
    end
  end

  // A set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       sel_err <= 1'b0;
    else if (set_err) sel_err <= 1'b1;
    else if (err_clr) sel_err <= 1'b0;
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit with behavioural model
module tb_pc_next_unit;

  localparam int DW = 32;
  localparam logic [DW-1:0] RV  = 32'h0000_0000;
  localparam logic [DW-1:0] EXC = 32'h0000_00FC;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    PCsource;
  logic [DW-1:0] jump_in, epc_in, result_in, ALU_out;
  logic          pc_write, pc_write_cond, zero, exc_req, err_clr;
  logic [DW-1:0] pc_out, EPC_out, next_pc;
  logic          in_trap, sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_next_unit #(.DATA_W(DW), .RESET_VECTOR(RV), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .reset(reset), .PCsource(PCsource),
    .jump_in(jump_in), .epc_in(epc_in), .result_in(result_in), .ALU_out(ALU_out),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero),
    .exc_req(exc_req), .err_clr(err_clr),
    .pc_out(pc_out), .EPC_out(EPC_out), .next_pc(next_pc),
    .in_trap(in_trap), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural PC/EPC/flag/trap state.
  logic [DW-1:0] m_pc = RV, m_epc = '0;
  logic          m_err = 1'b0, m_trap = 1'b0;

  function automatic logic [DW-1:0] m_target(input logic [DW-1:0] pc);
    case (PCsource)
      3'd0: return jump_in;
      3'd1: return epc_in;
      3'd2: return result_in;
      3'd3: return ALU_out;
      3'd4: return pc + 32'd4;
      default: return pc;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    logic          u, set;
    logic [DW-1:0] t;
    if (!reset) begin
      m_pc = RV; m_epc = '0; m_err = 1'b0; m_trap = 1'b0;
    end else begin
      set = 1'b0;
      if (m_trap) begin
        m_trap = 1'b0;
      end else begin
        u = pc_write | (pc_write_cond & zero);
        t = m_target(m_pc);
        if (exc_req) begin
          m_epc = m_pc; m_pc = EXC; m_trap = 1'b1;
        end else if (u && PCsource > 3'd4) begin
          set = 1'b1;
        end else if (u && ALIGN && t[1:0] != 2'b00) begin
          m_epc = m_pc; m_pc = EXC; m_trap = 1'b1; set = 1'b1;
        end else if (u) begin
          m_pc = t;
        end
      end
      if (set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pc", pc_out, m_pc);
    chk("model_epc", EPC_out, m_epc);
    chk("model_err", {31'd0, sel_err}, {31'd0, m_err});
    chk("model_trap", {31'd0, in_trap}, {31'd0, m_trap});
    chk("model_next_pc", next_pc, m_target(m_pc));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write = 0; pc_write_cond = 0; zero = 0; exc_req = 0; err_clr = 0; PCsource = 3'd4;
  endtask

  initial begin
    reset = 0; jump_in = '0; epc_in = '0; result_in = '0; ALU_out = '0;
    idle();
    #3;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_epc", EPC_out, 32'h0);
    chk("rst_err", {31'd0, sel_err}, 32'd0);
    chk("rst_trap", {31'd0, in_trap}, 32'd0);
    cyc(); cyc();
    reset = 1;

    // Sequential increment
    PCsource = 3'd4; pc_write = 1;
    cyc(); chk("inc1", pc_out, 32'd4);
    cyc(); chk("inc2", pc_out, 32'd8);
    cyc(); chk("inc3", pc_out, 32'd12);

    // Conditional branch
    idle(); PCsource = 3'd2; result_in = 32'h40; pc_write_cond = 1; zero = 0;
    cyc(); chk("br_not_taken", pc_out, 32'd12);
    zero = 1;
    cyc(); chk("br_taken", pc_out, 32'h40);

    // Jump and EPC selects
    idle(); PCsource = 3'd0; jump_in = 32'h20; pc_write = 1;
    cyc(); chk("jump", pc_out, 32'h20);
    PCsource = 3'd1; epc_in = 32'h80;
    cyc(); chk("epc_sel", pc_out, 32'h80);

    // Trap entry with competing update, then exc_req ignored in TRAP
    PCsource = 3'd3; ALU_out = 32'h100;
    cyc(); chk("alu_load", pc_out, 32'h100);
    ALU_out = 32'h200; exc_req = 1;
    cyc();
    chk("trap_epc", EPC_out, 32'h100);
    chk("trap_pc", pc_out, 32'hFC);
    chk("trap_flag", {31'd0, in_trap}, 32'd1);
    cyc();
    chk("trap_one_cycle", {31'd0, in_trap}, 32'd0);
    chk("no_nested_epc", EPC_out, 32'h100);
    chk("trap_ignores_write", pc_out, 32'hFC);

    // Illegal select
    idle(); PCsource = 3'd6; pc_write = 1;
    #1 chk("illegal_next_pc", next_pc, 32'hFC);
    cyc(); chk("illegal_hold", pc_out, 32'hFC);
    chk("illegal_err", {31'd0, sel_err}, 32'd1);
    idle();
    cyc(); chk("err_sticky", {31'd0, sel_err}, 32'd1);
    err_clr = 1;
    cyc(); chk("err_cleared", {31'd0, sel_err}, 32'd0);
    PCsource = 3'd7; pc_write = 1;
    cyc(); chk("set_beats_clr", {31'd0, sel_err}, 32'd1);
    idle(); err_clr = 1;
    cyc(); idle();

    // Wraparound
    PCsource = 3'd3; ALU_out = 32'hFFFF_FFFC; pc_write = 1;
    cyc(); chk("near_top", pc_out, 32'hFFFF_FFFC);
    PCsource = 3'd4;
    cyc(); chk("wrap", pc_out, 32'h0);

    // Misaligned target
    PCsource = 3'd3; ALU_out = 32'h102;
    cyc();
    if (ALIGN) begin
      chk("misalign_pc", pc_out, 32'hFC);
      chk("misalign_err", {31'd0, sel_err}, 32'd1);
      chk("misalign_epc", EPC_out, 32'h0);
    end else begin
      chk("misalign_pc", pc_out, 32'h102);
      chk("misalign_err", {31'd0, sel_err}, 32'd0);
    end
    idle(); err_clr = 1;
    cyc(); cyc(); idle();

    // Asynchronous reset mid-TRAP
    exc_req = 1;
    cyc(); chk("trap_before_rst", {31'd0, in_trap}, 32'd1);
    exc_req = 0;
    #2 reset = 0;
    #1;
    chk("async_pc", pc_out, 32'h0);
    chk("async_trap", {31'd0, in_trap}, 32'd0);
    chk("async_epc", EPC_out, 32'h0);
    cyc(); reset = 1;
    PCsource = 3'd4; pc_write = 1;
    cyc();
    chk("post_rst_run", pc_out, 32'd4);
    chk("post_rst_trap", {31'd0, in_trap}, 32'd0);
    idle();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
